// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: PC-source encodings, NOP word, fetch FSM states
// and the IF/ID payload record.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifid_word_t;

  // Jump destination: region bits of the jump's own pc+4, word index below.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0]   pc4,
                                                  input logic [JIDX_W-1:0] idx);
    return {pc4[XLEN-1:XLEN-4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched {inst, pc4} that ID could not accept.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       clear_i,
  input  ifid_word_t data_i,
  output logic       full_o,
  output ifid_word_t data_o
);

  logic       full_q, full_d;
  ifid_word_t data_q, data_d;

  // Clear wins over load, load wins over unload.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake, redirect/squash handling
// and the IF/ID register, with a skid entry covering ID stalls.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_en,
  input  logic [1:0]  pcsource,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;

  logic            branch_c;
  logic            jump_c;
  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            id_accept_c;

  logic            skid_load;
  logic            skid_unload;
  logic            skid_clear;
  logic            skid_full;
  ifid_word_t      skid_in;
  ifid_word_t      skid_out;

  // Branches resolve in MEM and override a stall; jumps from ID obey it.
  always_comb begin
    branch_c = 1'b0;
    jump_c   = 1'b0;
    case (pcsource)
      PCSRC_SEQ:    ;
      PCSRC_BRANCH: branch_c = 1'b1;
      PCSRC_JUMP:   jump_c   = !stall_en;
      default:      ;
    endcase
  end

  assign redirect_c  = branch_c || jump_c;
  assign target_c    = branch_c ? branch_target : jump_target(id_pc4_q, jump_index);
  assign pc_plus4_c  = pc_q + PC_STEP;
  assign id_accept_c = !stall_en || !id_valid_q;
  assign skid_in     = '{inst: imem_rdata, pc4: pc_plus4_c};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc4_d     = id_pc4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    // An unstalled ID consumes its word each cycle; refill with a bubble.
    if (!stall_en) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end

    case (state_q)
      FETCH: begin
        if (redirect_c) begin
          if (!imem_ready) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4_c;
          if (id_accept_c) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc4_d   = pc_plus4_c;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_c) begin
          state_d = FETCH;
        end else if (!stall_en) begin
          id_valid_d  = skid_full;
          id_inst_d   = skid_out.inst;
          id_pc4_d    = skid_out.pc4;
          skid_unload = 1'b1;
          state_d     = FETCH;
        end
      end

      DRAIN: begin
        // The outstanding word belongs to the squashed path and is dropped.
        if (imem_ready) begin
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (redirect_c) begin
      pc_d       = target_c;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      skid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_inst_q    <= NOP_INST;
      id_pc4_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (skid_in),
    .full_o   (skid_full),
    .data_o   (skid_out)
  );

  // Request is decoded from state so a zero-wait memory can answer in the same cycle.
  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus an instruction-stream
// scoreboard fed by memory responses and drained as ID consumes words.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_en;
  logic [1:0]  pcsource;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_en      (stall_en),
    .pcsource      (pcsource),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc4        (id_pc4)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  psrc;
    logic [31:0] btgt;
    logic [25:0] jidx;
    logic        rdy;
    logic        exp_req;
    logic        ck_addr;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        ck_pc4;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  logic        squash;
  int          checks;
  int          errors;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic vec_t mk(input int unsigned r, input int unsigned s, input int unsigned p,
                              input int unsigned b, input int unsigned j, input int unsigned rd,
                              input int unsigned eq, input int unsigned ca, input int unsigned ea,
                              input int unsigned ev, input int unsigned cp, input int unsigned ep);
    vec_t v;
    v.rst       = 1'(r);
    v.stall     = 1'(s);
    v.psrc      = 2'(p);
    v.btgt      = 32'(b);
    v.jidx      = 26'(j);
    v.rdy       = 1'(rd);
    v.exp_req   = 1'(eq);
    v.ck_addr   = 1'(ca);
    v.exp_addr  = 32'(ea);
    v.exp_valid = 1'(ev);
    v.ck_pc4    = 1'(cp);
    v.exp_pc4   = 32'(ep);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic        br;
    logic        jmp;
    logic [63:0] e;
    rst           = v.rst;
    stall_en      = v.stall;
    pcsource      = v.psrc;
    branch_target = v.btgt;
    jump_index    = v.jidx;
    #1;
    imem_ready = v.rdy & imem_req;
    imem_rdata = imem_ready ? inst_of(imem_addr) : 32'h0;
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(v.exp_req));
    if (v.ck_addr) chk({tag, ".addr"}, imem_addr, v.exp_addr);
    chk({tag, ".valid"}, 32'(id_valid), 32'(v.exp_valid));
    if (v.ck_pc4) chk({tag, ".pc4"}, id_pc4, v.exp_pc4);
    if (!id_valid) chk({tag, ".bubble"}, id_inst, 32'h0);

    br  = (v.psrc == 2'b01);
    jmp = (v.psrc == 2'b10) && !v.stall;
    if (v.rst) begin
      sb.delete();
      squash = 1'b0;
    end else begin
      if (id_valid && !v.stall && !br) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s.sb: got word with pc4 0x%08h, expected none", tag, id_pc4);
        end else begin
          e = sb.pop_front();
          chk({tag, ".sb_inst"}, id_inst, e[63:32]);
          chk({tag, ".sb_pc4"}, id_pc4, e[31:0]);
        end
      end
      if (br || jmp) begin
        sb.delete();
        squash = imem_req && !imem_ready;
      end else if (imem_ready) begin
        if (squash) squash = 1'b0;
        else sb.push_back({inst_of(imem_addr), imem_addr + 32'd4});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    squash = 1'b0;
    rst = 1'b1;
    stall_en = 1'b0;
    pcsource = 2'b00;
    branch_target = 32'h0;
    jump_index = 26'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;

    //           rst st ps btgt          jidx   rdy req ca addr          val cp pc4
    tbl.push_back(mk(1, 0, 0, 0,            0,     0,  0,  1, 32'h100,      0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h100,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h104,      1,  1, 32'h104));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h108,      1,  1, 32'h108));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1,  1,  1, 32'h10C,      1,  1, 32'h10C));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1,  0,  0, 0,            1,  1, 32'h10C));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1,  0,  0, 0,            1,  1, 32'h10C));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  0,  0, 0,            1,  1, 32'h10C));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0,  1,  1, 32'h110,      1,  1, 32'h110));
    tbl.push_back(mk(0, 0, 1, 32'h200,      0,     0,  1,  1, 32'h110,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h110,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h200,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h204,      1,  1, 32'h204));
    tbl.push_back(mk(0, 0, 2, 0,            'h100, 1,  1,  1, 32'h208,      1,  1, 32'h208));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h400,      0,  0, 0));
    tbl.push_back(mk(0, 1, 2, 0,            'h3FF, 0,  1,  1, 32'h404,      1,  1, 32'h404));
    tbl.push_back(mk(0, 1, 2, 0,            'h3FF, 1,  1,  1, 32'h404,      1,  1, 32'h404));
    tbl.push_back(mk(0, 1, 1, 32'h1000_0038, 0,    1,  0,  0, 0,            1,  1, 32'h404));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h1000_0038, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h1000_003C, 1, 1, 32'h1000_003C));
    tbl.push_back(mk(0, 0, 2, 0,            'h10,  1,  1,  1, 32'h1000_0040, 1, 1, 32'h1000_0040));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h1000_0040, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1,  1,  1, 32'h1000_0044, 1, 1, 32'h1000_0044));
    tbl.push_back(mk(1, 1, 0, 0,            0,     1,  0,  0, 0,            1,  1, 32'h1000_0044));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h100,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h104,      1,  1, 32'h104));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0,  1,  1, 32'h108,      1,  1, 32'h108));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0,  1,  1, 32'h108,      0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 0,    0,  1,  1, 32'h108,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h108,      0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'hFFFF_FFF8, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0,            0,     1,  1,  1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1,  1,  1, 32'h0,        1,  1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0,  1,  1, 32'h4,        1,  1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0,  1,  1, 32'h4,        0,  0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Stalled from reset: an empty IF/ID still fills, the next word goes to skid.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0),       "h0");
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 1, 0),       "h1");
    step(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h100, 0, 0, 0),       "h2");
    step(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h104, 1, 1, 32'h104), "h3");
    step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,       1, 1, 32'h104), "h4");
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,       1, 1, 32'h104), "h5");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h108, 1, 1, 32'h108), "h6");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h108, 0, 0, 0),       "h7");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
